// File: rtl/toggle_monitor.sv
// Counts toggles of an upstream T flip-flop's q output over a fixed window,
// reports the count on a valid/ready handshake and flags q/qbar violations.
module toggle_monitor #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned WIN   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             q_in,
   input  logic             qbar_in,
   input  logic             en,
   input  logic             ready,
   input  logic             err_clr,
   output logic             rise,
   output logic             fall,
   output logic [CNT_W-1:0] count,
   output logic             valid,
   output logic             sat,
   output logic             err
);

   localparam int unsigned WIN_W = $clog2(WIN);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      REPORT  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic             q_d;
   logic [WIN_W-1:0] win_cnt;
   logic [CNT_W-1:0] tog_cnt;
   logic             sat_acc;

   logic             toggle;
   logic             win_last;
   logic             tog_at_max;
   logic [CNT_W-1:0] tog_inc;

   logic             cnt_clr;
   logic             cnt_step;
   logic             rpt_load;
   logic             rpt_ack;

   assign toggle     = q_in ^ q_d;
   assign win_last   = (win_cnt == WIN_LAST);
   assign tog_at_max = (tog_cnt == CNT_MAX);
   assign tog_inc    = tog_at_max ? tog_cnt : tog_cnt + 1'b1;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; a dropped enable aborts the window before it can complete
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (en) begin
               state_nxt = MEASURE;
            end
         end
         MEASURE: begin
            if (!en) begin
               state_nxt = IDLE;
            end else if (win_last) begin
               state_nxt = REPORT;
            end
         end
         REPORT: begin
            if (ready) begin
               state_nxt = en ? MEASURE : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath controls decoded from state and inputs
   always_comb begin
      cnt_clr  = 1'b0;
      cnt_step = 1'b0;
      rpt_load = 1'b0;
      rpt_ack  = 1'b0;
      case (state)
         IDLE: begin
            cnt_clr = en;
         end
         MEASURE: begin
            if (en) begin
               rpt_load = win_last;
               cnt_step = !win_last;
            end
         end
         REPORT: begin
            if (ready) begin
               rpt_ack = 1'b1;
               cnt_clr = en;
            end
         end
         default: ;
      endcase
   end

   // Edge detection runs in every state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_d  <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         q_d  <= q_in;
         rise <= q_in & ~q_d;
         fall <= ~q_in & q_d;
      end
   end

   // Window and toggle counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_cnt <= '0;
         tog_cnt <= '0;
         sat_acc <= 1'b0;
      end else if (cnt_clr) begin
         win_cnt <= '0;
         tog_cnt <= '0;
         sat_acc <= 1'b0;
      end else if (cnt_step) begin
         win_cnt <= win_cnt + 1'b1;
         if (toggle) begin
            tog_cnt <= tog_inc;
            if (tog_at_max) begin
               sat_acc <= 1'b1;
            end
         end
      end
   end

   // Reported result; the final edge's toggle is folded in as it is loaded
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         sat   <= 1'b0;
         valid <= 1'b0;
      end else if (rpt_load) begin
         count <= toggle ? tog_inc : tog_cnt;
         sat   <= sat_acc | (toggle & tog_at_max);
         valid <= 1'b1;
      end else if (rpt_ack) begin
         valid <= 1'b0;
      end
   end

   // Sticky complementary-output check; a new violation beats a clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (q_in == qbar_in) begin
         err <= 1'b1;
      end else if (err_clr) begin
         err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_toggle_monitor.sv
// Scoreboard bench for toggle_monitor: a default instance (WIN=16, CNT_W=8)
// and a saturating instance (WIN=32, CNT_W=4) share clock, reset and q/qbar.
module tb_toggle_monitor;

   localparam int unsigned CNT_W_A = 8;
   localparam int unsigned WIN_A   = 16;
   localparam int unsigned CNT_W_B = 4;
   localparam int unsigned WIN_B   = 32;

   logic clk = 1'b0;
   logic rst;
   logic q_in;
   logic qbar_in;
   logic en_a, ready_a, en_b, ready_b;
   logic err_clr;

   logic               rise_a, fall_a, valid_a, sat_a, err_a;
   logic [CNT_W_A-1:0] count_a;
   logic               rise_b, fall_b, valid_b, sat_b, err_b;
   logic [CNT_W_B-1:0] count_b;

   typedef struct {
      int unsigned cnt;
      bit          sat;
   } exp_t;

   exp_t sb_a[$];
   exp_t sb_b[$];
   exp_t last_a;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   toggle_monitor #(.CNT_W(CNT_W_A), .WIN(WIN_A)) dut_a (
      .clk(clk), .rst(rst), .q_in(q_in), .qbar_in(qbar_in), .en(en_a),
      .ready(ready_a), .err_clr(err_clr), .rise(rise_a), .fall(fall_a),
      .count(count_a), .valid(valid_a), .sat(sat_a), .err(err_a)
   );

   toggle_monitor #(.CNT_W(CNT_W_B), .WIN(WIN_B)) dut_b (
      .clk(clk), .rst(rst), .q_in(q_in), .qbar_in(qbar_in), .en(en_b),
      .ready(ready_b), .err_clr(err_clr), .rise(rise_b), .fall(fall_b),
      .count(count_b), .valid(valid_b), .sat(sat_b), .err(err_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_q(input logic v);
      q_in    = v;
      qbar_in = ~v;
   endtask

   // Entry edge plus WIN-1 measured edges; the last edge's input is left
   // driven so the caller owns the reporting edge. Pushes the expectation.
   task automatic drive_window(input int mode, input bit use_b);
      int unsigned t;
      int unsigned cmax;
      int          win;
      logic        v;
      exp_t        e;
      t    = 0;
      win  = use_b ? int'(WIN_B) : int'(WIN_A);
      cmax = use_b ? ((1 << CNT_W_B) - 1) : ((1 << CNT_W_A) - 1);
      if (use_b) en_b = 1'b1;
      else       en_a = 1'b1;
      tick();
      ready_a = 1'b0;
      ready_b = 1'b0;
      for (int i = 1; i <= win; i++) begin
         case (mode)
            0:       v = ~q_in;
            1:       v = 1'($urandom_range(0, 1));
            default: v = q_in;
         endcase
         if (v != q_in) t++;
         drive_q(v);
         if (i < win) tick();
      end
      e.cnt = (t > cmax) ? cmax : t;
      e.sat = (t > cmax);
      if (use_b) sb_b.push_back(e);
      else       sb_a.push_back(e);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3;
      checks++;
      if ({rise_a, fall_a, valid_a, sat_a, err_a} !== 5'b0 || count_a !== '0) begin
         errors++;
         $display("FAIL reset_a: rise=%b fall=%b valid=%b sat=%b err=%b count=%0d, want all 0",
                  rise_a, fall_a, valid_a, sat_a, err_a, count_a);
      end
      checks++;
      if ({rise_b, fall_b, valid_b, sat_b, err_b} !== 5'b0 || count_b !== '0) begin
         errors++;
         $display("FAIL reset_b: rise=%b fall=%b valid=%b sat=%b err=%b count=%0d, want all 0",
                  rise_b, fall_b, valid_b, sat_b, err_b, count_b);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_count();
      exp_t e;
      drive_window(0, 1'b0);
      checks++;
      if (valid_a !== 1'b0) begin
         errors++;
         $display("FAIL count_early: valid=%b one edge before window end, want 0", valid_a);
      end
      tick();
      checks++;
      if (valid_a !== 1'b1) begin
         errors++;
         $display("FAIL count_latency: valid=%b after WIN edges, want 1", valid_a);
      end
      checks++;
      if (sb_a.size() == 0) begin
         errors++;
         $display("FAIL count_sb: scoreboard empty at report");
      end else begin
         e = sb_a.pop_front();
         last_a = e;
         if (count_a !== 8'(e.cnt) || sat_a !== e.sat) begin
            errors++;
            $display("FAIL count_value: count=%0d sat=%b, want count=%0d sat=%b",
                     count_a, sat_a, e.cnt, e.sat);
         end
      end
      for (int i = 0; i < 3; i++) begin
         drive_q(~q_in);
         tick();
         checks++;
         if (valid_a !== 1'b1 || count_a !== 8'(last_a.cnt)) begin
            errors++;
            $display("FAIL count_hold%0d: valid=%b count=%0d, want valid=1 count=%0d",
                     i, valid_a, count_a, last_a.cnt);
         end
      end
      en_a    = 1'b0;
      ready_a = 1'b1;
      tick();
      ready_a = 1'b0;
      checks++;
      if (valid_a !== 1'b0 || count_a !== 8'(last_a.cnt)) begin
         errors++;
         $display("FAIL count_ack: valid=%b count=%0d, want valid=0 count=%0d",
                  valid_a, count_a, last_a.cnt);
      end
   endtask

   task automatic test_abort();
      bit seen;
      en_a = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         drive_q(~q_in);
         tick();
      end
      en_a = 1'b0;
      drive_q(~q_in);
      tick();
      checks++;
      if (valid_a !== 1'b0 || count_a !== 8'(last_a.cnt)) begin
         errors++;
         $display("FAIL abort: valid=%b count=%0d, want valid=0 count=%0d",
                  valid_a, count_a, last_a.cnt);
      end
      seen = 1'b0;
      for (int i = 0; i < int'(WIN_A) + 2; i++) begin
         drive_q(~q_in);
         tick();
         if (valid_a !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL abort_idle: valid=1 seen after abort, want 0 throughout");
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      for (int n = 0; n < 3; n++) begin
         drive_window(1, 1'b0);
         checks++;
         if (valid_a !== 1'b0) begin
            errors++;
            $display("FAIL b2b_early%0d: valid=%b, want 0", n, valid_a);
         end
         tick();
         checks++;
         if (sb_a.size() == 0) begin
            errors++;
            $display("FAIL b2b_sb%0d: scoreboard empty at report", n);
         end else begin
            e = sb_a.pop_front();
            last_a = e;
            if (valid_a !== 1'b1 || count_a !== 8'(e.cnt) || sat_a !== e.sat) begin
               errors++;
               $display("FAIL b2b_value%0d: valid=%b count=%0d sat=%b, want valid=1 count=%0d sat=%b",
                        n, valid_a, count_a, sat_a, e.cnt, e.sat);
            end
         end
         ready_a = 1'b1;
      end
      en_a = 1'b0;
      tick();
      ready_a = 1'b0;
      checks++;
      if (valid_a !== 1'b0) begin
         errors++;
         $display("FAIL b2b_ack: valid=%b, want 0", valid_a);
      end
   endtask

   task automatic test_err();
      exp_t e;
      drive_q(1'b1);
      qbar_in = 1'b1;
      tick();
      drive_q(1'b1);
      checks++;
      if (err_a !== 1'b1 || err_b !== 1'b1) begin
         errors++;
         $display("FAIL err_set: err_a=%b err_b=%b, want 1", err_a, err_b);
      end
      drive_window(0, 1'b0);
      tick();
      checks++;
      if (sb_a.size() == 0) begin
         errors++;
         $display("FAIL err_sb: scoreboard empty at report");
      end else begin
         e = sb_a.pop_front();
         last_a = e;
         if (valid_a !== 1'b1 || count_a !== 8'(e.cnt) || err_a !== 1'b1) begin
            errors++;
            $display("FAIL err_window: valid=%b count=%0d err=%b, want valid=1 count=%0d err=1",
                     valid_a, count_a, err_a, e.cnt);
         end
      end
      en_a    = 1'b0;
      ready_a = 1'b1;
      tick();
      ready_a = 1'b0;
      err_clr = 1'b1;
      qbar_in = q_in;
      tick();
      drive_q(q_in);
      checks++;
      if (err_a !== 1'b1) begin
         errors++;
         $display("FAIL err_set_wins: err=%b, want 1", err_a);
      end
      tick();
      err_clr = 1'b0;
      checks++;
      if (err_a !== 1'b0 || err_b !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: err_a=%b err_b=%b, want 0", err_a, err_b);
      end
      tick();
      checks++;
      if (err_a !== 1'b0) begin
         errors++;
         $display("FAIL err_stays_clear: err=%b, want 0", err_a);
      end
   endtask

   task automatic test_report_edges();
      exp_t e;
      e.cnt = 0;
      e.sat = 1'b0;
      drive_window(1, 1'b0);
      tick();
      checks++;
      if (sb_a.size() == 0) begin
         errors++;
         $display("FAIL edges_sb: scoreboard empty at report");
      end else begin
         e = sb_a.pop_front();
         last_a = e;
         if (valid_a !== 1'b1 || count_a !== 8'(e.cnt)) begin
            errors++;
            $display("FAIL edges_report: valid=%b count=%0d, want valid=1 count=%0d",
                     valid_a, count_a, e.cnt);
         end
      end
      drive_q(1'b0);
      tick();
      tick();
      checks++;
      if (rise_a !== 1'b0 || fall_a !== 1'b0) begin
         errors++;
         $display("FAIL edges_quiet: rise=%b fall=%b, want 0 0", rise_a, fall_a);
      end
      drive_q(1'b1);
      tick();
      checks++;
      if (rise_a !== 1'b1 || fall_a !== 1'b0) begin
         errors++;
         $display("FAIL edges_rise: rise=%b fall=%b, want 1 0", rise_a, fall_a);
      end
      tick();
      checks++;
      if (rise_a !== 1'b0 || fall_a !== 1'b0) begin
         errors++;
         $display("FAIL edges_rise_end: rise=%b fall=%b, want 0 0", rise_a, fall_a);
      end
      drive_q(1'b0);
      tick();
      checks++;
      if (rise_a !== 1'b0 || fall_a !== 1'b1) begin
         errors++;
         $display("FAIL edges_fall: rise=%b fall=%b, want 0 1", rise_a, fall_a);
      end
      tick();
      checks++;
      if (fall_a !== 1'b0 || valid_a !== 1'b1 || count_a !== 8'(e.cnt)) begin
         errors++;
         $display("FAIL edges_stable: fall=%b valid=%b count=%0d, want 0 1 %0d",
                  fall_a, valid_a, count_a, e.cnt);
      end
      en_a    = 1'b0;
      ready_a = 1'b1;
      tick();
      ready_a = 1'b0;
   endtask

   task automatic test_sat();
      exp_t e;
      for (int n = 0; n < 2; n++) begin
         drive_window((n == 0) ? 0 : 2, 1'b1);
         checks++;
         if (valid_b !== 1'b0) begin
            errors++;
            $display("FAIL sat_early%0d: valid=%b, want 0", n, valid_b);
         end
         tick();
         checks++;
         if (sb_b.size() == 0) begin
            errors++;
            $display("FAIL sat_sb%0d: scoreboard empty at report", n);
         end else begin
            e = sb_b.pop_front();
            if (valid_b !== 1'b1 || count_b !== 4'(e.cnt) || sat_b !== e.sat) begin
               errors++;
               $display("FAIL sat_value%0d: valid=%b count=%0d sat=%b, want valid=1 count=%0d sat=%b",
                        n, valid_b, count_b, sat_b, e.cnt, e.sat);
            end
         end
         ready_b = 1'b1;
      end
      en_b = 1'b0;
      tick();
      ready_b = 1'b0;
      checks++;
      if (valid_b !== 1'b0) begin
         errors++;
         $display("FAIL sat_ack: valid=%b, want 0", valid_b);
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      bit   seen;
      en_a = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         drive_q(~q_in);
         tick();
      end
      #2;
      rst  = 1'b1;
      en_a = 1'b0;
      #1;
      checks++;
      if ({rise_a, fall_a, valid_a, sat_a, err_a} !== 5'b0 || count_a !== '0) begin
         errors++;
         $display("FAIL arst_measure: rise=%b fall=%b valid=%b sat=%b err=%b count=%0d, want all 0",
                  rise_a, fall_a, valid_a, sat_a, err_a, count_a);
      end
      #2;
      rst = 1'b0;
      last_a.cnt = 0;
      drive_window(0, 1'b0);
      tick();
      checks++;
      if (valid_a !== 1'b1) begin
         errors++;
         $display("FAIL arst_prep: valid=%b, want 1", valid_a);
      end
      if (sb_a.size() != 0) e = sb_a.pop_front();
      #2;
      rst  = 1'b1;
      en_a = 1'b0;
      #1;
      checks++;
      if (valid_a !== 1'b0 || count_a !== '0 || sat_a !== 1'b0) begin
         errors++;
         $display("FAIL arst_report: valid=%b count=%0d sat=%b, want 0 0 0",
                  valid_a, count_a, sat_a);
      end
      #2;
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < int'(WIN_A) + 2; i++) begin
         drive_q(~q_in);
         tick();
         if (valid_a !== 1'b0 || count_a !== '0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL arst_no_partial: valid or count nonzero after reset release");
      end
      drive_window(1, 1'b0);
      checks++;
      if (valid_a !== 1'b0) begin
         errors++;
         $display("FAIL arst_restart_early: valid=%b, want 0", valid_a);
      end
      tick();
      checks++;
      if (sb_a.size() == 0) begin
         errors++;
         $display("FAIL arst_sb: scoreboard empty at report");
      end else begin
         e = sb_a.pop_front();
         if (valid_a !== 1'b1 || count_a !== 8'(e.cnt) || sat_a !== e.sat) begin
            errors++;
            $display("FAIL arst_restart: valid=%b count=%0d sat=%b, want valid=1 count=%0d sat=%b",
                     valid_a, count_a, sat_a, e.cnt, e.sat);
         end
      end
      en_a    = 1'b0;
      ready_a = 1'b1;
      tick();
      ready_a = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst     = 1'b1;
      en_a    = 1'b0;
      ready_a = 1'b0;
      en_b    = 1'b0;
      ready_b = 1'b0;
      err_clr = 1'b0;
      drive_q(1'b0);
      last_a.cnt = 0;
      last_a.sat = 1'b0;
      test_reset();
      test_count();
      test_abort();
      test_back_to_back();
      test_err();
      test_report_edges();
      test_sat();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/toggle_monitor.md
TOGGLE_MONITOR -- requirements
Module: toggle_monitor

Interface
REQ-001 Parameter: CNT_W, default 8, width of the toggle count and the count output.
REQ-002 Parameter: WIN, default 16, measurement window length in clock cycles (WIN >= 2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 q_in  input  1  q output of the upstream T flip-flop.
REQ-006 qbar_in  input  1  qbar output of the upstream T flip-flop.
REQ-007 en  input  1  measurement enable.
REQ-008 ready  input  1  consumer accepts the reported count.
REQ-009 err_clr  input  1  clears the sticky error flag.
REQ-010 rise  output  1  one-cycle pulse, q_in rising edge detected.
REQ-011 fall  output  1  one-cycle pulse, q_in falling edge detected.
REQ-012 count  output  CNT_W  toggles counted in the last completed window.
REQ-013 valid  output  1  count is valid, held until accepted.
REQ-014 sat  output  1  count saturated in the reported window.
REQ-015 err  output  1  sticky flag, complementary-output violation seen.

Function
REQ-016 The block SHALL keep register q_d, loaded with q_in on every clock edge in every state; a toggle is q_in != q_d at that edge.
REQ-017 At each edge rise SHALL load (q_in & ~q_d) and fall SHALL load (~q_in & q_d), so each is high for exactly one cycle per edge detected.
REQ-018 The FSM SHALL have three states: IDLE, MEASURE, REPORT.
REQ-019 IDLE -> MEASURE at an edge where en=1; win_cnt and tog_cnt SHALL clear to 0 on that edge.
REQ-020 In MEASURE, at each edge, win_cnt SHALL increment and tog_cnt SHALL increment on a toggle, saturating at 2^CNT_W-1; the internal sat bit SHALL set on an increment attempted at maximum.
REQ-021 The window SHALL cover exactly WIN edges after entry; on the edge where win_cnt == WIN-1, that edge's toggle is included, count and sat are loaded, valid is set to 1, and the state goes to REPORT.
REQ-022 Latency: en sampled at edge k SHALL give valid=1 after edge k+WIN.
REQ-023 If en=0 at any edge in MEASURE, the block SHALL abort to IDLE; no valid; count is unchanged.
REQ-024 In REPORT, count and sat SHALL stay stable while valid=1; toggles SHALL NOT be counted, but rise and fall SHALL still pulse.
REQ-025 At an edge in REPORT with ready=1, valid SHALL clear; next state is MEASURE with counters cleared if en=1, else IDLE.
REQ-026 ready outside REPORT SHALL be ignored; en changes in REPORT SHALL not affect valid.
REQ-027 err SHALL set at any edge where q_in == qbar_in and stay set until err_clr=1 at an edge; if set and clear occur on the same edge, set wins.
REQ-028 count SHALL retain its last reported value after valid clears.

Reset
REQ-029 While rst=1, without waiting for a clock: state=IDLE; q_d, win_cnt, tog_cnt=0; rise, fall, valid, sat, err=0; count=0.
REQ-030 Reset asserted in MEASURE or REPORT SHALL abort the operation; no partial count is reported after release.
REQ-031 After rst deasserts, the first edge with en=1 SHALL start a window per REQ-019.

Verification
REQ-032 rst=1 mid-stream, no clock edge -> all outputs 0 immediately; state IDLE.
REQ-033 WIN=16, CNT_W=8, en=1, q_in toggling every cycle, qbar_in = ~q_in -> valid after 16 edges, count=16, sat=0, held 3 cycles with ready=0, clears 1 edge after ready=1.
REQ-034 WIN=32, CNT_W=4, toggling every cycle -> count=15, sat=1.
REQ-035 en dropped at the 5th edge of the window -> no valid, state IDLE, count holds the previous value.
REQ-036 q_in=qbar_in=1 for one cycle -> err=1 stays set across windows until err_clr pulse, then 0.
REQ-037 Single rising then falling edge of q_in during REPORT -> rise then fall one-cycle pulses; reported count unchanged.
